// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared writeback definitions for the register-file write-port arbiter and its requesters.
// Execute and the LSU use the same request shape, so it lives here.
package regfile_wb_arbiter_pkg;

   localparam int XLEN = 32;
   localparam int IDXW = 5;

   typedef struct packed {
      logic            valid;
      logic [IDXW-1:0] idx;
      logic [XLEN-1:0] data;
   } wb_req_t;

   // Which requester won the most recent transfer; the other one wins the next tie.
   typedef enum logic {
      GRANT_REQ0 = 1'b0,
      GRANT_REQ1 = 1'b1
   } grant_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: purely combinational grant and next-state computation.
// The caller owns the state register, which lets other shared ports reuse this block.
module rr_arb2
   import regfile_wb_arbiter_pkg::*;
(
   input  logic [1:0] i_valid,
   input  logic       i_hold,
   input  grant_e     i_last_grant,
   output logic [1:0] o_grant,
   output grant_e     o_next_grant
);

   logic [1:0] w_grant;

   always_comb begin
      w_grant      = 2'b00;
      o_next_grant = i_last_grant;
      if (!i_hold) begin
         case (i_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = (i_last_grant == GRANT_REQ1) ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
         endcase
      end
      if (w_grant[0]) begin
         o_next_grant = GRANT_REQ0;
      end else if (w_grant[1]) begin
         o_next_grant = GRANT_REQ1;
      end
   end

   assign o_grant = w_grant;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register-file write port between ALU and LSU writeback,
// with a one-entry registered output stage and read-port bypass from that stage.
//
// Handshake: a request transfers when valid and ready are both high at a rising edge.
// ready depends only on the valids, hold and the round-robin state, never on idx/data.
// A requester keeps valid, idx and data stable until accepted; it may withdraw earlier.
module regfile_wb_arbiter #(
   parameter int XLEN = regfile_wb_arbiter_pkg::XLEN,
   parameter int IDXW = regfile_wb_arbiter_pkg::IDXW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            hold,
   input  logic            req0_valid,
   input  logic [IDXW-1:0] req0_idx,
   input  logic [XLEN-1:0] req0_data,
   output logic            req0_ready,
   input  logic            req1_valid,
   input  logic [IDXW-1:0] req1_idx,
   input  logic [XLEN-1:0] req1_data,
   output logic            req1_ready,
   output logic            wr_en,
   output logic [IDXW-1:0] wr_idx,
   output logic [XLEN-1:0] wr_data,
   input  logic [IDXW-1:0] rd_idx1,
   input  logic [IDXW-1:0] rd_idx2,
   output logic            fwd_hit1,
   output logic [XLEN-1:0] fwd_data1,
   output logic            fwd_hit2,
   output logic [XLEN-1:0] fwd_data2
);
   import regfile_wb_arbiter_pkg::*;

   grant_e          r_last_grant;
   grant_e          w_next_grant;
   logic [1:0]      w_grant;
   logic            w_any_grant;
   logic [IDXW-1:0] w_sel_idx;
   logic [XLEN-1:0] w_sel_data;

   logic            r_wr_en;
   logic [IDXW-1:0] r_wr_idx;
   logic [XLEN-1:0] r_wr_data;

   logic            w_hit1;
   logic            w_hit2;

   rr_arb2 u_rr_arb2 (
      .i_valid      ({req1_valid, req0_valid}),
      .i_hold       (hold),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant),
      .o_next_grant (w_next_grant)
   );

   // Gating with rst_n keeps both requesters stalled for the whole reset pulse.
   assign req0_ready  = rst_n & w_grant[0];
   assign req1_ready  = rst_n & w_grant[1];
   assign w_any_grant = |w_grant;
   assign w_sel_idx   = w_grant[1] ? req1_idx  : req0_idx;
   assign w_sel_data  = w_grant[1] ? req1_data : req0_data;

   // x0 writes are accepted and still rotate priority, but never raise wr_en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= GRANT_REQ1;
         r_wr_en      <= 1'b0;
         r_wr_idx     <= '0;
         r_wr_data    <= '0;
      end else begin
         r_last_grant <= w_next_grant;
         if (w_any_grant) begin
            r_wr_en   <= (w_sel_idx != '0);
            r_wr_idx  <= w_sel_idx;
            r_wr_data <= w_sel_data;
         end else begin
            r_wr_en   <= 1'b0;
         end
      end
   end

   assign wr_en   = r_wr_en;
   assign wr_idx  = r_wr_idx;
   assign wr_data = r_wr_data;

   assign w_hit1    = r_wr_en && (r_wr_idx != '0) && (r_wr_idx == rd_idx1);
   assign w_hit2    = r_wr_en && (r_wr_idx != '0) && (r_wr_idx == rd_idx2);
   assign fwd_hit1  = w_hit1;
   assign fwd_hit2  = w_hit2;
   assign fwd_data1 = w_hit1 ? r_wr_data : '0;
   assign fwd_data2 = w_hit2 ? r_wr_data : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic against a behavioural model of the arbitration rules.
module tb_regfile_wb_arbiter;

  localparam int XLEN = 32;
  localparam int IDXW = 5;
  localparam int SBW  = IDXW + XLEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            hold;
  logic            req0_valid, req1_valid;
  logic [IDXW-1:0] req0_idx, req1_idx;
  logic [XLEN-1:0] req0_data, req1_data;
  logic            req0_ready, req1_ready;
  logic            wr_en;
  logic [IDXW-1:0] wr_idx;
  logic [XLEN-1:0] wr_data;
  logic [IDXW-1:0] rd_idx1, rd_idx2;
  logic            fwd_hit1, fwd_hit2;
  logic [XLEN-1:0] fwd_data1, fwd_data2;

  regfile_wb_arbiter #(.XLEN(XLEN), .IDXW(IDXW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (hold),
    .req0_valid (req0_valid),
    .req0_idx   (req0_idx),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_idx   (req1_idx),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .rd_idx1    (rd_idx1),
    .rd_idx2    (rd_idx2),
    .fwd_hit1   (fwd_hit1),
    .fwd_data1  (fwd_data1),
    .fwd_hit2   (fwd_hit2),
    .fwd_data2  (fwd_data2)
  );

  // ---------------- scoreboard / model state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  int              m_last;      // requester of the most recent transfer (0 or 1)
  logic            m_wr_en;
  logic [IDXW-1:0] m_wr_idx;
  logic [XLEN-1:0] m_wr_data;
  logic [SBW-1:0]  exp_q[$];    // writes expected to appear on the write port, in order
  logic            g0, g1;      // model grants of the most recent cycle

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_last    = 1;
    m_wr_en   = 1'b0;
    m_wr_idx  = '0;
    m_wr_data = '0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    logic h1, h2;
    h1 = m_wr_en && (m_wr_idx != 0) && (m_wr_idx == rd_idx1);
    h2 = m_wr_en && (m_wr_idx != 0) && (m_wr_idx == rd_idx2);
    check_eq("wr_en",     wr_en,     m_wr_en);
    check_eq("wr_idx",    wr_idx,    m_wr_idx);
    check_eq("wr_data",   wr_data,   m_wr_data);
    check_eq("fwd_hit1",  fwd_hit1,  h1);
    check_eq("fwd_data1", fwd_data1, h1 ? m_wr_data : '0);
    check_eq("fwd_hit2",  fwd_hit2,  h2);
    check_eq("fwd_data2", fwd_data2, h2 ? m_wr_data : '0);
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input logic v0, input logic [IDXW-1:0] i0, input logic [XLEN-1:0] d0,
                       input logic v1, input logic [IDXW-1:0] i1, input logic [XLEN-1:0] d1,
                       input logic h, input logic [IDXW-1:0] r1, input logic [IDXW-1:0] r2);
    logic           e0, e1;
    logic [SBW-1:0] ent;
    req0_valid = v0; req0_idx = i0; req0_data = d0;
    req1_valid = v1; req1_idx = i1; req1_data = d1;
    hold = h; rd_idx1 = r1; rd_idx2 = r2;
    #1;
    // Lone requester wins; on contention the one that did not win last time wins.
    e0 = !h && v0 && (!v1 || m_last == 1);
    e1 = !h && v1 && (!v0 || m_last == 0);
    check_eq("req0_ready", req0_ready, e0);
    check_eq("req1_ready", req1_ready, e1);
    check_outputs();
    if (m_wr_en) begin
      check_eq("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        ent = exp_q.pop_front();
        check_eq("sb_commit", {wr_idx, wr_data}, ent);
      end
    end
    g0 = e0;
    g1 = e1;
    @(posedge clk);
    if (e0 || e1) begin
      m_last    = e0 ? 0 : 1;
      m_wr_idx  = e0 ? i0 : i1;
      m_wr_data = e0 ? d0 : d1;
      m_wr_en   = (m_wr_idx != 0);
      if (m_wr_en) exp_q.push_back({m_wr_idx, m_wr_data});
    end else begin
      m_wr_en = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [IDXW-1:0] r1, input logic [IDXW-1:0] r2);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, r1, r2);
  endtask

  task automatic probe(input logic [IDXW-1:0] r1, input logic [IDXW-1:0] r2);
    rd_idx1 = r1;
    rd_idx2 = r2;
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_wr_en",  wr_en,  1'b0);
    check_eq("rst_wr_idx", wr_idx, '0);
    check_eq("rst_wr_data", wr_data, '0);
    check_eq("rst_ready0", req0_ready, 1'b0);
    check_eq("rst_ready1", req1_ready, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic            p0v, p1v;
  logic [IDXW-1:0] p0i, p1i;
  logic [XLEN-1:0] p0d, p1d;

  initial begin
    hold = 1'b0;
    req0_valid = 1'b1; req0_idx = 5'd3; req0_data = 32'h1;
    req1_valid = 1'b1; req1_idx = 5'd4; req1_data = 32'h2;
    rd_idx1 = '0; rd_idx2 = '0;
    #2;
    do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Single ALU write, then bypass from the output stage.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, 5'd5, '0);
    probe(5'd5, 5'd0);
    check_eq("tp1_wr_en",   wr_en,    1'b1);
    check_eq("tp1_wr_idx",  wr_idx,   5'd5);
    check_eq("tp1_wr_data", wr_data,  32'hDEADBEEF);
    check_eq("tp1_hit1",    fwd_hit1, 1'b1);
    idle('0, '0);

    // Continuous contention alternates starting with req0.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, '0, '0);
      check_eq("tp2_wr_idx", wr_idx, (k % 2 == 0) ? 5'd1 : 5'd2);
    end

    // x0 write from the LSU: accepted, never written or forwarded.
    cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0);
    check_eq("tp3_wr_en", wr_en,    1'b0);
    check_eq("tp3_hit1",  fwd_hit1, 1'b0);
    check_eq("tp3_hit2",  fwd_hit2, 1'b0);

    // hold freezes grants; afterwards req0 (not last winner) goes first.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1, '0, '0);
      check_eq("tp4_hold_wr_en", wr_en, 1'b0);
    end
    cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, '0, '0);
    check_eq("tp4_first_idx", wr_idx, 5'd3);

    // Both read ports hit the same pending write; a different index misses.
    cycle(1'b1, 5'd7, 32'h1234, 1'b0, '0, '0, 1'b0, '0, '0);
    probe(5'd7, 5'd7);
    check_eq("tp5_hit1",  fwd_hit1,  1'b1);
    check_eq("tp5_hit2",  fwd_hit2,  1'b1);
    check_eq("tp5_data1", fwd_data1, 32'h1234);
    check_eq("tp5_data2", fwd_data2, 32'h1234);
    probe(5'd7, 5'd8);
    check_eq("tp5_miss_hit2",  fwd_hit2,  1'b0);
    check_eq("tp5_miss_data2", fwd_data2, 32'h0);
    idle('0, '0);

    // Reset while a write is pending discards it and restores req0 priority.
    cycle(1'b1, 5'd9, 32'hABCD, 1'b0, '0, '0, 1'b0, '0, '0);
    do_reset();
    cycle(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0, 1'b0, '0, '0);
    check_eq("tp6_winner_idx", wr_idx, 5'd10);

    // Randomized traffic; pending requests stay stable or are withdrawn.
    p0v = 1'b0; p1v = 1'b0; p0i = '0; p1i = '0; p0d = '0; p1d = '0;
    for (int n = 0; n < 400; n++) begin
      logic            h;
      logic [IDXW-1:0] r1, r2;
      if (!p0v) begin
        p0v = ($urandom_range(0, 99) < 60);
        p0i = IDXW'($urandom_range(0, 31));
        p0d = $urandom;
      end else if ($urandom_range(0, 9) == 0) begin
        p0v = 1'b0;
      end
      if (!p1v) begin
        p1v = ($urandom_range(0, 99) < 60);
        p1i = IDXW'($urandom_range(0, 31));
        p1d = $urandom;
      end else if ($urandom_range(0, 9) == 0) begin
        p1v = 1'b0;
      end
      h  = ($urandom_range(0, 9) == 0);
      r1 = $urandom_range(0, 1) ? m_wr_idx : IDXW'($urandom_range(0, 31));
      r2 = $urandom_range(0, 1) ? m_wr_idx : IDXW'($urandom_range(0, 31));
      cycle(p0v, p0i, p0d, p1v, p1i, p1d, h, r1, r2);
      if (g0) p0v = 1'b0;
      if (g1) p1v = 1'b0;
    end
    idle('0, '0);
    idle('0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: req0 (ALU/execute) and req1 (load/store unit).
- Arbitrates round-robin and registers the granted write into a one-entry output stage that drives the register-file write port.
- Provides bypass data for the two read ports while a write sits in the output stage and has not yet reached the array.
- Sits between execute/LSU writeback and the register file.

Parameters:
- XLEN, 32, data width of write data and forwarded data
- IDXW, 5, register index width (32 architectural registers, x0 hard-wired zero)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  freeze arbitration (debug/pipeline freeze); no grants while high
- req0_valid  in  1  ALU writeback request
- req0_idx  in  IDXW  destination register
- req0_data  in  XLEN  write data
- req0_ready  out  1  req0 accepted this cycle
- req1_valid  in  1  LSU writeback request
- req1_idx  in  IDXW  destination register
- req1_data  in  XLEN  write data
- req1_ready  out  1  req1 accepted this cycle
- wr_en  out  1  register-file write enable (registered)
- wr_idx  out  IDXW  register-file write index (registered)
- wr_data  out  XLEN  register-file write data (registered)
- rd_idx1  in  IDXW  read-port-1 index being looked up
- rd_idx2  in  IDXW  read-port-2 index being looked up
- fwd_hit1  out  1  output stage holds a pending write to rd_idx1
- fwd_data1  out  XLEN  bypass data for port 1
- fwd_hit2  out  1  same for port 2
- fwd_data2  out  XLEN  bypass data for port 2

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - wr_en=0, wr_idx=0, wr_data=0.
  - last_grant=1, so req0 wins the first contention.
  - req*_ready=0 while reset is asserted.
- Grant logic (combinational, same cycle as valid):
  - hold=1: no grant; both ready=0.
  - Only one valid: that requester is granted.
  - Both valid: the requester that is not last_grant is granted.
  - At most one ready is high per cycle.
  - ready is a pure function of the valids, hold and last_grant; it never depends on data or idx.
- Handshake:
  - A transfer occurs when valid and ready are both high at a rising edge.
  - A requester must keep valid, idx and data stable until it is accepted.
  - Deasserting valid before acceptance is permitted; no state is affected.
- Output stage (1-cycle latency):
  - On the edge after a grant: wr_en=1 and wr_idx/wr_data load the granted request. The register file commits on the following edge.
  - With no grant: wr_en=0; wr_idx/wr_data retain their old values.
- last_grant: updates to the granted requester only on an actual transfer; otherwise unchanged.
- x0 writes:
  - The request is accepted normally (ready asserted, last_grant updates).
  - The output stage loads wr_en=0.
  - Forwarding never hits index 0.
- Forwarding (combinational):
  - fwd_hitN = wr_en && wr_idx!=0 && wr_idx==rd_idxN.
  - fwd_dataN = wr_data when hit, else 0.
  - Both ports may hit the same entry at once.
- Simultaneous same-index requests: serialized by round-robin. The later grant overwrites on the following cycle, so the last committed value belongs to the second winner.
- hold asserted mid-stream: the output stage still drains (wr_en=1 for one cycle if a grant happened the previous edge), then wr_en=0 until hold falls.
- Reset mid-operation: the pending output-stage write is discarded (wr_en forced 0) and is never committed.

Decomposition:
- Shared package: XLEN and IDXW constants, and a writeback-request struct {valid, idx, data} reused by execute/LSU.
- One natural sub-module, rr_arb2: a 2-way round-robin arbiter (valids, hold, state → grants, next state), reusable for memory-port sharing.
- Output stage and forwarding compare stay in the top module.

Test Plan:
- Reset, then only req0_valid, idx=5, data=0xDEADBEEF → req0_ready=1 same cycle; next cycle wr_en=1, wr_idx=5, wr_data=0xDEADBEEF; fwd_hit1=1 when rd_idx1=5.
- Both valid every cycle for 4 cycles (req0 idx=1 data=0x11, req1 idx=2 data=0x22), each held until accepted → grants alternate 0,1,0,1 starting with req0; wr_idx sequence 1,2,1,2.
- req1 writes idx=0 data=0xFFFFFFFF → req1_ready=1, next cycle wr_en=0, fwd_hit1/2=0 with rd_idx1=rd_idx2=0.
- hold=1 with both valid for 3 cycles → both ready=0, wr_en=0 throughout; hold=0 → req0 (not last_grant) granted first.
- Grant to idx=7 data=0x1234, then rd_idx1=rd_idx2=7 → fwd_hit1=fwd_hit2=1, fwd_data1=fwd_data2=0x1234; rd_idx2=8 → fwd_hit2=0, fwd_data2=0.
- Grant issued, rst_n pulled low before the next edge completes → wr_en=0 immediately; after release, last_grant is back to 1 and req0 wins contention.
